// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate constants, byte width and the
// transmit arbiter state encoding.
package uart_pkg;

    localparam int CLK_HZ       = 27_000_000;
    localparam int BAUD         = 115_200;
    localparam int DELAY_FRAMES = CLK_HZ / BAUD;
    localparam int UART_DW      = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: starting just after the last granted
// requester, returns the first requesting index as one-hot and binary.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_id,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IDW-1:0]     pick_idx
);

    int             cand;
    logic [IDW-1:0] cand_idx;
    logic           found;

    // Scan last_id+1, last_id+2, ... modulo NUM_REQ; first hit wins.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        found       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_id) + k) % NUM_REQ;
            cand_idx = IDW'(cand);
            if (!found && req[cand_idx]) begin
                found                 = 1'b1;
                pick_onehot[cand_idx] = 1'b1;
                pick_idx              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit serializer among NUM_REQ byte-stream sources.
// Round-robin grant with packet lock, burst cap and stall timeout, feeding
// a one-entry holding register on the serializer's valid/ready port.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int MAX_BURST     = 16,
    parameter  int STALL_TIMEOUT = 1024,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [UART_DW*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [UART_DW-1:0]         tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [IDW-1:0]             grant_id,
    output logic                       busy
);

    localparam int SCW = $clog2(STALL_TIMEOUT + 1);

    arb_state_t           state, state_nxt;
    logic [7:0]           burst_cnt;
    logic [SCW-1:0]       stall_cnt;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_any;
    logic                 gnt_valid;
    logic                 gnt_last;
    logic [UART_DW-1:0]   gnt_data;
    logic                 can_load;
    logic                 accept;
    logic                 burst_hit;
    logic                 stall_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req         (req_valid),
        .last_id     (grant_id),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    assign pick_any = |pick_onehot;
    assign can_load = !tx_valid || tx_ready;
    assign busy     = (state == ARB_GRANT) || tx_valid;

    // Select the granted requester's valid, last flag and byte.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[UART_DW*i +: UART_DW];
            end
        end
    end

    // Next-state logic, ready demux and release decision.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        burst_hit = 1'b0;
        stall_hit = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                req_ready[grant_id] = can_load;
                accept    = gnt_valid && can_load;
                burst_hit = (burst_cnt + 8'd1) == 8'(MAX_BURST);
                stall_hit = !gnt_valid && (stall_cnt == SCW'(STALL_TIMEOUT - 1));
                if ((accept && (gnt_last || burst_hit)) || stall_hit) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant index and burst/stall counters; a fresh grant clears both counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id  <= IDW'(NUM_REQ - 1);
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_any) begin
                grant_id  <= pick_idx;
                burst_cnt <= '0;
                stall_cnt <= '0;
            end
        end else begin
            if (accept) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
            // A valid byte blocked by a full holding register is not a stall.
            if (gnt_valid) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + SCW'(1);
            end
        end
    end

    // Holding register: load on accept, empty on drain; both together reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (accept) begin
            tx_data  <= gnt_data;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, packet ordering, round-robin,
// burst cap, stall timeout, serializer back-pressure and mid-packet reset.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  srcq [NR][$];
    logic [NR-1:0] src_en;
    logic [7:0]  txq[$];
    logic [11:0] accq[$];
    logic [11:0] exp_acc[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .MAX_BURST     (16),
        .STALL_TIMEOUT (1024)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present each source queue head on the requester ports.
    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_en[i] && srcq[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = srcq[i][0][7:0];
                req_last[i]       = srcq[i][0][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    // Log handshakes of this cycle, advance one clock, retire accepted bytes.
    task automatic cycle();
        logic [NR-1:0] hs;
        hs = req_valid & req_ready;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        for (int i = 0; i < NR; i++)
            if (hs[i]) accq.push_back({4'(i), req_data[8*i +: 8]});
        @(posedge clk);
        #2;
        for (int i = 0; i < NR; i++)
            if (hs[i]) void'(srcq[i].pop_front());
        drive();
        #1;
    endtask

    task automatic wait_acc(input string tag, input int n_needed, input int budget);
        int n;
        n = 0;
        while (accq.size() < n_needed && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, (accq.size() >= n_needed), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            done = (srcq[0].size() == 0) && (srcq[1].size() == 0) &&
                   (srcq[2].size() == 0) && (srcq[3].size() == 0) &&
                   !tx_valid && !busy;
            if (!done) begin
                cycle();
                n++;
            end
        end
        chk(tag, done, 1);
    endtask

    // Compare accepted (id,byte) log and transmitted bytes with expectations.
    task automatic check_logs(input string tag);
        chk({tag, "_acc_n"}, accq.size(), exp_acc.size());
        chk({tag, "_tx_n"}, txq.size(), exp_acc.size());
        for (int i = 0; i < exp_acc.size(); i++) begin
            if (i < accq.size()) chk({tag, "_acc"}, accq[i], exp_acc[i]);
            if (i < txq.size())  chk({tag, "_tx"}, txq[i], exp_acc[i][7:0]);
        end
        accq.delete();
        txq.delete();
        exp_acc.delete();
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        tx_ready  = 1'b1;
        src_en    = '1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (2) @(posedge clk);
        #2;
        drive();
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_grant_id", grant_id, 2'd3);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cycle();

        // Single packet from requester 0.
        srcq[0].push_back({1'b0, 8'h41});
        srcq[0].push_back({1'b0, 8'h42});
        srcq[0].push_back({1'b1, 8'h43});
        drive();
        #1;
        chk("p_idle_ready", req_ready, 4'b0000);
        chk("p_idle_gid", grant_id, 2'd3);
        cycle();
        chk("p_gnt_ready", req_ready, 4'b0001);
        chk("p_gnt_gid", grant_id, 2'd0);
        chk("p_gnt_busy", busy, 1'b1);
        chk("p_gnt_txv", tx_valid, 1'b0);
        cycle();
        chk("p_b1_txv", tx_valid, 1'b1);
        chk("p_b1_data", tx_data, 8'h41);
        cycle();
        chk("p_b2_data", tx_data, 8'h42);
        cycle();
        chk("p_b3_data", tx_data, 8'h43);
        chk("p_rel_ready", req_ready, 4'b0000);
        chk("p_rel_busy", busy, 1'b1);
        cycle();
        chk("p_end_busy", busy, 1'b0);
        chk("p_end_txv", tx_valid, 1'b0);
        exp_acc = '{12'h041, 12'h042, 12'h043};
        check_logs("pkt");

        // Round-robin: req0, req1, req3 all pending after a req0 grant.
        srcq[1].push_back({1'b0, 8'h11});
        srcq[1].push_back({1'b1, 8'h12});
        srcq[3].push_back({1'b1, 8'h31});
        srcq[0].push_back({1'b1, 8'h01});
        drive();
        #1;
        wait_done("rr_done", 200);
        exp_acc = '{12'h111, 12'h112, 12'h331, 12'h001};
        check_logs("rr");

        // Burst cap: req2 streams 20 bytes, req0 pending.
        for (int k = 0; k < 20; k++) srcq[2].push_back({(k == 19), 8'(8'h80 + k)});
        srcq[0].push_back({1'b1, 8'h05});
        drive();
        #1;
        wait_done("burst_done", 300);
        for (int k = 0; k < 16; k++) exp_acc.push_back({4'd2, 8'(8'h80 + k)});
        exp_acc.push_back(12'h005);
        for (int k = 16; k < 20; k++) exp_acc.push_back({4'd2, 8'(8'h80 + k)});
        check_logs("burst");

        // Stall timeout: req0 sends one byte then goes quiet, req1 waits.
        srcq[0].push_back({1'b0, 8'h50});
        srcq[1].push_back({1'b1, 8'h60});
        drive();
        #1;
        wait_acc("stall_first", 1, 50);
        n = 0;
        while (busy && n < 2000) begin
            cycle();
            n++;
        end
        chk("stall_len", n, 1024);
        cycle();
        chk("stall_next_gid", grant_id, 2'd1);
        chk("stall_next_ready", req_ready, 4'b0010);
        wait_done("stall_done", 50);
        exp_acc = '{12'h050, 12'h160};
        check_logs("stall");

        // Serializer back-pressure for 50 cycles.
        srcq[0].push_back({1'b0, 8'hA1});
        srcq[0].push_back({1'b0, 8'hA2});
        srcq[0].push_back({1'b1, 8'hA3});
        tx_ready = 1'b0;
        drive();
        #1;
        wait_acc("bp_first", 1, 50);
        for (int k = 0; k < 50; k++) begin
            chk("bp_ready", req_ready, 4'b0000);
            chk("bp_data", tx_data, 8'hA1);
            chk("bp_txv", tx_valid, 1'b1);
            chk("bp_busy", busy, 1'b1);
            cycle();
        end
        tx_ready = 1'b1;
        #1;
        wait_done("bp_done", 50);
        exp_acc = '{12'h0A1, 12'h0A2, 12'h0A3};
        check_logs("bp");

        // Reset mid-grant with a byte held.
        for (int k = 0; k < 4; k++) srcq[3].push_back({1'b0, 8'(8'hC0 + k)});
        tx_ready = 1'b0;
        drive();
        #1;
        n = 0;
        while (!tx_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("mr_loaded", tx_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_tx_valid", tx_valid, 1'b0);
        chk("mr_ready", req_ready, 4'b0000);
        chk("mr_grant_id", grant_id, 2'd3);
        chk("mr_busy", busy, 1'b0);
        chk("mr_tx_data", tx_data, 8'h00);
        srcq[3].delete();
        drive();
        cycle();
        tx_ready = 1'b1;
        rst_n = 1'b1;
        accq.delete();
        txq.delete();
        repeat (3) cycle();
        chk("mr_no_replay", txq.size(), 0);
        chk("mr_idle_txv", tx_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
